// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, constants and address-split helpers for icache_dm
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    INSTALL = 2'd2
  } icache_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic int off_bits(input int words_per_line);
    return $clog2(words_per_line) + 2;
  endfunction

  function automatic int idx_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int num_lines, input int words_per_line);
    return 32 - off_bits(words_per_line) - idx_bits(num_lines);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - refill FSM: line burst on the memory side, install and kill tracking
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4,
  localparam int OFF = off_bits(WORDS_PER_LINE),
  localparam int IW  = idx_bits(NUM_LINES),
  localparam int TW  = tag_bits(NUM_LINES, WORDS_PER_LINE),
  localparam int WW  = $clog2(WORDS_PER_LINE)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [31:0]   i_adr,
  input  logic          i_miss,
  input  logic          i_invalidate,
  input  logic          i_mem_ack,
  output icache_state_t o_state,
  output logic [31:0]   o_mem_adr,
  output logic          o_mem_read,
  output logic          o_wr_en,
  output logic [IW-1:0] o_idx,
  output logic [WW-1:0] o_word,
  output logic [TW-1:0] o_tag,
  output logic          o_install,
  output logic          o_install_valid
);

  localparam logic [31:0]   LINE_MASK = 32'(WORDS_PER_LINE * 4 - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_LINE - 1);

  icache_state_t r_state;
  logic [WW-1:0] r_cnt;
  logic [31:0]   r_base;
  logic          r_kill;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
      r_kill  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_miss && !i_invalidate) begin
            r_state <= REFILL;
            r_base  <= i_adr & ~LINE_MASK;
            r_cnt   <= '0;
          end
        end
        REFILL: begin
          // a flush mid-burst lets the burst finish but poisons the install
          if (i_invalidate) r_kill <= 1'b1;
          if (i_mem_ack) begin
            r_cnt <= r_cnt + WW'(1);
            if (r_cnt == LAST_WORD) r_state <= INSTALL;
          end
        end
        INSTALL: begin
          r_state <= IDLE;
          r_kill  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_state         = r_state;
  assign o_mem_read      = (r_state == REFILL);
  assign o_mem_adr       = o_mem_read ? (r_base | {{(30-WW){1'b0}}, r_cnt, 2'b00}) : 32'h0;
  assign o_wr_en         = o_mem_read & i_mem_ack;
  assign o_idx           = r_base[OFF+IW-1:OFF];
  assign o_tag           = r_base[31:OFF+IW];
  assign o_word          = r_cnt;
  assign o_install       = (r_state == INSTALL);
  assign o_install_valid = !r_kill;

endmodule

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache; arrays and hit path
module icache_dm
  import icache_pkg::*;
#(
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ADR_SI,
  input  logic        ADR_VALID_SI,
  output logic [31:0] IC_INST_SI,
  output logic        IC_STALL_SI,
  input  logic        INVALIDATE_SM,
  output logic [31:0] MEM_ADR_SC,
  output logic        MEM_READ_SC,
  input  logic [31:0] MEM_DATA_SM,
  input  logic        MEM_ACK_SM
);

  localparam int OFF = off_bits(WORDS_PER_LINE);
  localparam int IW  = idx_bits(NUM_LINES);
  localparam int TW  = tag_bits(NUM_LINES, WORDS_PER_LINE);
  localparam int WW  = $clog2(WORDS_PER_LINE);

  logic [NUM_LINES-1:0] r_valid;
  logic [TW-1:0]        r_tag  [NUM_LINES];
  logic [31:0]          r_data [NUM_LINES][WORDS_PER_LINE];

  icache_state_t w_state;
  logic [IW-1:0] w_idx, w_fill_idx;
  logic [WW-1:0] w_word, w_fill_word;
  logic [TW-1:0] w_tag, w_fill_tag;
  logic          w_hit, w_wr_en, w_install, w_install_valid;

  assign w_idx  = ADR_SI[OFF+IW-1:OFF];
  assign w_word = ADR_SI[OFF-1:2];
  assign w_tag  = ADR_SI[31:OFF+IW];

  assign w_hit       = (w_state == IDLE) & ADR_VALID_SI & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign IC_INST_SI  = w_hit ? r_data[w_idx][w_word] : NOP_INST;
  assign IC_STALL_SI = (w_state != IDLE) | (ADR_VALID_SI & !w_hit);

  icache_refill_ctrl #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_refill_ctrl (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_adr           (ADR_SI),
    .i_miss          (ADR_VALID_SI & !w_hit),
    .i_invalidate    (INVALIDATE_SM),
    .i_mem_ack       (MEM_ACK_SM),
    .o_state         (w_state),
    .o_mem_adr       (MEM_ADR_SC),
    .o_mem_read      (MEM_READ_SC),
    .o_wr_en         (w_wr_en),
    .o_idx           (w_fill_idx),
    .o_word          (w_fill_word),
    .o_tag           (w_fill_tag),
    .o_install       (w_install),
    .o_install_valid (w_install_valid)
  );

  // invalidate wins over a same-cycle install
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else if (INVALIDATE_SM) begin
      r_valid <= '0;
    end else if (w_install) begin
      r_valid[w_fill_idx] <= w_install_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_install) r_tag[w_fill_idx] <= w_fill_tag;
    if (w_wr_en)   r_data[w_fill_idx][w_fill_word] <= MEM_DATA_SM;
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - directed self-checking bench for icache_dm
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ADR_SI;
  logic        ADR_VALID_SI;
  logic [31:0] IC_INST_SI;
  logic        IC_STALL_SI;
  logic        INVALIDATE_SM;
  logic [31:0] MEM_ADR_SC;
  logic        MEM_READ_SC;
  logic [31:0] MEM_DATA_SM;
  logic        MEM_ACK_SM;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  icache_dm #(.NUM_LINES(64), .WORDS_PER_LINE(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ADR_SI        (ADR_SI),
    .ADR_VALID_SI  (ADR_VALID_SI),
    .IC_INST_SI    (IC_INST_SI),
    .IC_STALL_SI   (IC_STALL_SI),
    .INVALIDATE_SM (INVALIDATE_SM),
    .MEM_ADR_SC    (MEM_ADR_SC),
    .MEM_READ_SC   (MEM_READ_SC),
    .MEM_DATA_SM   (MEM_DATA_SM),
    .MEM_ACK_SM    (MEM_ACK_SM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Serves one line refill: 2-cycle ack latency, data dbase+k for word k.
  task automatic serve_line(input logic [31:0] base, input logic [31:0] dbase,
                            input int inv_k, input logic [31:0] redir);
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 20 && !MEM_READ_SC; n++) @(negedge clk);
      chk("mem_read", {31'b0, MEM_READ_SC}, 32'd1);
      chk("mem_adr", MEM_ADR_SC, base + 32'(4 * k));
      chk("stall_refill", {31'b0, IC_STALL_SI}, 32'd1);
      @(negedge clk);
      INVALIDATE_SM = 1'b0;
      chk("adr_stable", MEM_ADR_SC, base + 32'(4 * k));
      @(negedge clk);
      MEM_ACK_SM  = 1'b1;
      MEM_DATA_SM = dbase + 32'(k);
      @(negedge clk);
      MEM_ACK_SM  = 1'b0;
      MEM_DATA_SM = 32'hDEAD_BEEF;
      if (k == 0 && redir != 32'h0) ADR_SI = redir;
      if (k == inv_k) INVALIDATE_SM = 1'b1;
    end
    chk("install_no_read", {31'b0, MEM_READ_SC}, 32'd0);
    chk("install_stall", {31'b0, IC_STALL_SI}, 32'd1);
  endtask

  task automatic fetch(input string tag, input logic [31:0] adr,
                       input logic exp_stall, input logic [31:0] exp_inst);
    ADR_SI       = adr;
    ADR_VALID_SI = 1'b1;
    #1;
    chk({tag, "_stall"}, {31'b0, IC_STALL_SI}, {31'b0, exp_stall});
    chk({tag, "_inst"}, IC_INST_SI, exp_inst);
    chk({tag, "_no_read"}, {31'b0, MEM_READ_SC}, 32'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    ADR_SI        = 32'h0;
    ADR_VALID_SI  = 1'b0;
    INVALIDATE_SM = 1'b0;
    MEM_DATA_SM   = 32'h0;
    MEM_ACK_SM    = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_stall", {31'b0, IC_STALL_SI}, 32'd0);
    chk("rst_inst", IC_INST_SI, 32'h13);
    chk("rst_read", {31'b0, MEM_READ_SC}, 32'd0);
    chk("rst_adr", MEM_ADR_SC, 32'h0);
    ADR_VALID_SI = 1'b1;
    #1;
    chk("rst_stall_follows", {31'b0, IC_STALL_SI}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // cold miss and refill of 0x100
    fetch("cold", 32'h100, 1'b1, 32'h13);
    serve_line(32'h100, 32'hA0, -1, 32'h0);
    @(negedge clk);
    fetch("hit0", 32'h100, 1'b0, 32'hA0);
    @(negedge clk);
    fetch("hit1", 32'h104, 1'b0, 32'hA1);
    @(negedge clk);
    fetch("hit2", 32'h108, 1'b0, 32'hA2);
    @(negedge clk);
    fetch("hit3", 32'h10C, 1'b0, 32'hA3);

    // idle with no request
    @(negedge clk);
    ADR_VALID_SI = 1'b0;
    #1;
    chk("idle_stall", {31'b0, IC_STALL_SI}, 32'd0);
    chk("idle_inst", IC_INST_SI, 32'h13);

    // conflict eviction: 0x500 shares the index of 0x100
    @(negedge clk);
    fetch("conf_miss", 32'h500, 1'b1, 32'h13);
    serve_line(32'h500, 32'hB0, -1, 32'h0);
    @(negedge clk);
    fetch("conf_hit", 32'h508, 1'b0, 32'hB2);
    @(negedge clk);
    fetch("evicted", 32'h100, 1'b1, 32'h13);
    serve_line(32'h100, 32'hA0, -1, 32'h0);
    @(negedge clk);
    fetch("refetch", 32'h10C, 1'b0, 32'hA3);

    // invalidate after the 2nd ack of the 0x200 refill
    @(negedge clk);
    fetch("inv_miss", 32'h200, 1'b1, 32'h13);
    serve_line(32'h200, 32'hC0, 1, 32'h0);
    @(negedge clk);
    fetch("killed_line", 32'h200, 1'b1, 32'h13);
    fetch("flushed_line", 32'h100, 1'b1, 32'h13);
    ADR_VALID_SI = 1'b0;

    // invalidate in idle blocks the refill start for that cycle
    @(negedge clk);
    fetch("inv_idle", 32'h300, 1'b1, 32'h13);
    INVALIDATE_SM = 1'b1;
    @(negedge clk);
    chk("inv_idle_no_refill", {31'b0, MEM_READ_SC}, 32'd0);
    INVALIDATE_SM = 1'b0;
    serve_line(32'h300, 32'hD0, -1, 32'h0);
    @(negedge clk);
    fetch("after_inv_idle", 32'h304, 1'b0, 32'hD1);

    // redirect during refill does not move the burst
    @(negedge clk);
    fetch("redir_miss", 32'h600, 1'b1, 32'h13);
    serve_line(32'h600, 32'hE0, -1, 32'h700);
    @(negedge clk);
    fetch("redir_hit", 32'h604, 1'b0, 32'hE1);

    // asynchronous reset mid-refill
    @(negedge clk);
    fetch("rstmid_miss", 32'h100, 1'b1, 32'h13);
    @(negedge clk);
    chk("rstmid_read", {31'b0, MEM_READ_SC}, 32'd1);
    repeat (2) @(negedge clk);
    MEM_ACK_SM  = 1'b1;
    MEM_DATA_SM = 32'hA0;
    @(negedge clk);
    MEM_ACK_SM  = 1'b0;
    chk("rstmid_adr1", MEM_ADR_SC, 32'h104);
    reset_n = 1'b0;
    #1;
    chk("rstmid_read_off", {31'b0, MEM_READ_SC}, 32'd0);
    chk("rstmid_adr_off", MEM_ADR_SC, 32'h0);
    chk("rstmid_stall", {31'b0, IC_STALL_SI}, 32'd1);
    chk("rstmid_inst", IC_INST_SI, 32'h13);
    @(negedge clk);
    reset_n = 1'b1;
    fetch("rstmid_refetch", 32'h100, 1'b1, 32'h13);
    serve_line(32'h100, 32'hA0, -1, 32'h0);
    @(negedge clk);
    fetch("rstmid_hit", 32'h100, 1'b0, 32'hA0);

    // hit with simultaneous invalidate returns data, then line is gone
    @(negedge clk);
    INVALIDATE_SM = 1'b1;
    fetch("hit_inv", 32'h108, 1'b0, 32'hA2);
    @(negedge clk);
    INVALIDATE_SM = 1'b0;
    fetch("post_inv", 32'h108, 1'b1, 32'h13);
    ADR_VALID_SI = 1'b0;
    #1;
    chk("end_idle_stall", {31'b0, IC_STALL_SI}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache; the responder end of the fetch-side Icache interface.
- Takes the fetch address and valid from ifetch and returns the instruction the same cycle on a hit, or stalls.
- On a miss it refills one line from the memory/bus side, one word per acknowledged request.
- Sits between ifetch and the instruction memory port; INVALIDATE_SM supports fence.i and exception flush.

Parameters:
- NUM_LINES, 64, number of cache lines (power of 2, ≥2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ADR_SI  in  32  fetch address; bits [1:0] ignored.
- ADR_VALID_SI  in  1  fetch request valid.
- IC_INST_SI  out  32  instruction word, valid when IC_STALL_SI=0.
- IC_STALL_SI  out  1  high = instruction not available this cycle.
- INVALIDATE_SM  in  1  clear all lines (fence.i / flush).
- MEM_ADR_SC  out  32  word address of the current refill request.
- MEM_READ_SC  out  1  refill word request valid.
- MEM_DATA_SM  in  32  refill data, valid with MEM_ACK_SM.
- MEM_ACK_SM  in  1  request accepted and data returned this cycle.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE)+2 bits; word select = ADR[OFF-1:2].
  - IDX = log2(NUM_LINES) bits at ADR[OFF+IDX-1:OFF].
  - TAG = 32-OFF-IDX upper bits.
- Storage: valid[NUM_LINES] and tag[NUM_LINES] in flops; data array in flops with combinational read.
- Hit (combinational): state==IDLE & ADR_VALID_SI & valid[idx] & tag[idx]==ADR tag.
  - IC_INST_SI = data[idx][word]; otherwise 32'h13 (nop).
- IC_STALL_SI = ADR_VALID_SI & !hit. Forced to 1 whenever state!=IDLE, even if ADR_VALID_SI=0.
- FSM states IDLE, REFILL, INSTALL:
  - IDLE -> REFILL when ADR_VALID_SI & !hit & !INVALIDATE_SM. Latch line base address (ADR with low OFF bits cleared) and index/tag; word counter=0.
  - REFILL:
    - MEM_READ_SC=1; MEM_ADR_SC = base + 4*counter.
    - On MEM_ACK_SM: write MEM_DATA_SM to data[latched idx][counter] and increment counter.
    - The ack on counter==WORDS_PER_LINE-1 moves to INSTALL.
    - No abort: ADR_SI changing during refill (redirect) does not stop the burst.
  - INSTALL: tag[idx]<=latched tag; valid[idx]<=!kill. Next state IDLE; MEM_READ_SC=0.
  - Refill-to-hit latency: the cycle after INSTALL the same address hits.
- INVALIDATE_SM:
  - Clears all valid bits at the next edge, in any state.
  - If asserted in REFILL or INSTALL, set kill; the burst completes but the line installs invalid. kill clears on return to IDLE.
  - Invalidate in INSTALL has priority over the install's valid set.
  - In IDLE with a miss, no refill starts that cycle.
- Simultaneous hit and INVALIDATE_SM in IDLE: hit data still returned that cycle (combinational); line invalid from the next cycle.
- Counter wraps to 0 on entering REFILL; it never exceeds WORDS_PER_LINE-1.
- Reset (asynchronous, including mid-refill):
  - State IDLE; all valid=0; counter=0; kill=0.
  - MEM_READ_SC=0; MEM_ADR_SC=0.
  - IC_STALL_SI follows ADR_VALID_SI; IC_INST_SI=32'h13.
  - Tag/data arrays are not reset.
- MEM side handshake: MEM_READ_SC and MEM_ADR_SC stay stable until MEM_ACK_SM. An ACK with MEM_READ_SC=0 is ignored.

Decomposition:
- Package icache_pkg:
  - state enum icache_state_t {IDLE, REFILL, INSTALL}.
  - Constant NOP_INST=32'h13.
  - Functions/localparams for OFF/IDX/TAG widths.
- Sub-module icache_refill_ctrl:
  - Holds the FSM, word counter, latched base/idx/tag and kill.
  - Drives the MEM_* outputs and the data-array write enable, index and word.
  - Top level keeps the arrays and the hit/output logic.

Test Plan:
- Cold miss: reset, ADR_SI=0x100, ADR_VALID_SI=1; memory acks each request after 2 cycles, words 0xA0..0xA3.
  - Expect MEM_ADR_SC 0x100,0x104,0x108,0x10C in order.
  - IC_STALL_SI=1 throughout; cycle after INSTALL, IC_STALL_SI=0 and IC_INST_SI=0xA0.
- Hits after refill: ADR 0x104, 0x108, 0x10C on consecutive cycles.
  - Expect IC_STALL_SI=0 and IC_INST_SI=0xA1, 0xA2, 0xA3, with no MEM_READ_SC.
- Conflict eviction (defaults): after line 0x100 is filled, fetch 0x500 (same index, new tag).
  - Expect a refill from 0x500; a later 0x100 misses again.
- Invalidate mid-refill: pulse INVALIDATE_SM after the 2nd ack of the 0x200 refill.
  - Expect all 4 words still requested; 0x200 misses after INSTALL; 0x100 also misses.
- Reset mid-refill: assert reset_n=0 after the 1st ack.
  - Expect MEM_READ_SC=0 immediately (async); state IDLE; the next fetch of 0x100 misses.
- Idle and redirect:
  - ADR_VALID_SI=0 in IDLE: expect IC_STALL_SI=0, IC_INST_SI=0x13.
  - ADR_SI changing during REFILL: refill still completes at the original base address.
